// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory with a valid/ready request and
// response channel. Each access spends LATENCY cycles in WAIT. One access is
// outstanding at a time, and busy is high while it is in flight.
// Optional feature: define DMEM_ADDR_CHECK_EN to flag out-of-range addresses
// through resp_err. When it is undefined, addresses alias modulo DEPTH_WORDS.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    generate
        if (LATENCY < 1 || LATENCY > 15 || DEPTH_WORDS < 4 ||
            (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_param
            $error("data_mem_responder: illegal DEPTH_WORDS or LATENCY");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic               write_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic               range_ok;
    logic               access_now;
    logic               mem_we;
    logic               unused_addr_bits;

    logic [31:0] mem [DEPTH_WORDS];

    // The access happens on the edge that leaves WAIT. Reset suppresses it,
    // so a reset during WAIT aborts the store cleanly.
    assign access_now = !rst && (state == S_WAIT) && (cnt == 4'd0);
    assign mem_we     = access_now && write_q && range_ok;

`ifdef DMEM_ADDR_CHECK_EN
    logic oor_q;
    logic err_q;

    assign range_ok         = !oor_q;
    assign resp_err         = err_q;
    assign unused_addr_bits = ^req_addr[1:0];

    // Range flag is captured with the request. The error output is set at the access edge
    // and cleared by the next accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && req_valid && req_ready) begin
            oor_q <= (req_addr[31:2] >= 30'(DEPTH_WORDS));
            err_q <= 1'b0;
        end else if (access_now) begin
            err_q <= oor_q;
        end
    end
`else
    assign range_ok         = 1'b1;
    assign resp_err         = 1'b0;
    assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
`endif

    // Request/response FSM. All handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q   <= req_write;
                        idx_q     <= req_addr[IDX_W+1:2];
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= S_WAIT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= (write_q || !range_ok) ? 32'd0 : mem[idx_q];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane store into the array. The array is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule
